// File: rtl/led4_pipe.sv
// ---------------------------------------------------------------------------
// led4_pipe -- 4-LED chaser with prescaler and selectable pattern.
//
// One LED is lit at all times. Each time the prescaler reaches DIV-1 the lit
// position advances according to MODE. The LED drive comes straight from a
// flop, so it cannot glitch.
//
// Parameters:
//   DIV        clock cycles per LED step (1..2^24)
//   MODE       0 = rotate left, 1 = rotate right, 2 = bounce, 3 = as 0
//   ACTIVE_LOW 0 = lit LED drives 1, 1 = lit LED drives 0
//
// Ports:
//   clock    in   sole clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   diode    out  [3:0] registered LED drive
// ---------------------------------------------------------------------------
module led4_pipe #(
    parameter int unsigned DIV        = 1,
    parameter int unsigned MODE       = 0,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [3:0] diode
);

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2
    } mode_e;

    // Illegal MODE values fall back to rotate-left.
    localparam mode_e MODE_SEL = (MODE == 1) ? MODE_ROTR   :
                                 (MODE == 2) ? MODE_BOUNCE : MODE_ROTL;

    localparam int unsigned    CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(DIV - 1);
    localparam logic [3:0]     POS_INIT   = 4'b0001;
    localparam logic [3:0]     DIODE_INIT = (ACTIVE_LOW != 0) ? ~POS_INIT : POS_INIT;

    logic [CW-1:0] cnt;
    logic [3:0]    pos;
    logic          dir;        // bounce direction: 0 = up, 1 = down

    logic          step;
    logic          one_hot;
    logic [3:0]    pos_nxt;
    logic          dir_nxt;

    assign step    = (cnt == CNT_LAST);
    assign one_hot = (pos == 4'b0001) || (pos == 4'b0010) ||
                     (pos == 4'b0100) || (pos == 4'b1000);

    // Next position/direction, applied only on a step.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        pos_nxt = POS_INIT;
        dir_nxt = 1'b0;
        if (one_hot) begin
            case (MODE_SEL)
                MODE_ROTR: begin
                    pos_nxt = {pos[0], pos[3:1]};
                end
                MODE_BOUNCE: begin
                    if (!dir) begin
                        if (pos[3]) begin
                            // Up at the top end cannot arise normally; turn around.
                            pos_nxt = 4'b0100;
                            dir_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos << 1;
                            dir_nxt = pos[2];      // loading 1000 turns us down
                        end
                    end else begin
                        if (pos[0]) begin
                            pos_nxt = 4'b0010;
                            dir_nxt = 1'b0;
                        end else begin
                            pos_nxt = pos >> 1;
                            dir_nxt = !pos[1];     // loading 0001 turns us up
                        end
                    end
                end
                default: begin
                    pos_nxt = {pos[2:0], pos[3]};
                end
            endcase
        end
    end

    // NOTE: the async reset sits in the sensitivity list so diode returns to its
    // idle value immediately, without waiting for a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            pos   <= POS_INIT;
            dir   <= 1'b0;
            diode <= DIODE_INIT;
        end else begin
            // NOTE: non-blocking assignments -- every flop samples pre-edge values.
            if (step) begin
                cnt   <= '0;
                pos   <= pos_nxt;
                dir   <= dir_nxt;
                diode <= (ACTIVE_LOW != 0) ? ~pos_nxt : pos_nxt;
            end else begin
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led4_pipe.sv
// ---------------------------------------------------------------------------
// tb_led4_pipe -- scoreboard bench for led4_pipe.
//
// Four instances run side by side on one clock and reset:
//   u_def : defaults (DIV=1, MODE=0, ACTIVE_LOW=0)
//   u_bnc : MODE=2, DIV=1
//   u_div : DIV=3, MODE=0
//   u_rr  : MODE=1, ACTIVE_LOW=1
// Expected diode values are pushed to per-instance queues before each edge and
// popped and compared after it.
// ---------------------------------------------------------------------------
module tb_led4_pipe;

    logic       clock;
    logic       reset_n;
    logic [3:0] d_def, d_bnc, d_div, d_rr;

    int total = 0;
    int bad   = 0;

    logic [3:0] q_def[$];
    logic [3:0] q_bnc[$];
    logic [3:0] q_div[$];
    logic [3:0] q_rr[$];

    led4_pipe u_def (.clock(clock), .reset_n(reset_n), .diode(d_def));
    led4_pipe #(.DIV(1), .MODE(2), .ACTIVE_LOW(0)) u_bnc (.clock(clock), .reset_n(reset_n), .diode(d_bnc));
    led4_pipe #(.DIV(3), .MODE(0), .ACTIVE_LOW(0)) u_div (.clock(clock), .reset_n(reset_n), .diode(d_div));
    led4_pipe #(.DIV(1), .MODE(1), .ACTIVE_LOW(1)) u_rr  (.clock(clock), .reset_n(reset_n), .diode(d_rr));

    // 40 ns period, rising edges at 20, 60, 100, ...
    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

    // Edge-by-edge expectations counted from reset release.
    logic [3:0] exp_def [10] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                                 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    logic [3:0] exp_bnc [10] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    logic [3:0] exp_div [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                                 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    logic [3:0] exp_rr  [10] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111,
                                 4'b1011, 4'b1101, 4'b1110, 4'b0111, 4'b1011};

    task automatic test_reset();
        // Reset asserted at 10 ns; outputs must be at idle before any edge.
        #5;
        total++; if (d_def !== 4'b0001) begin bad++; $display("FAIL reset_def got=%b exp=0001", d_def); end
        total++; if (d_bnc !== 4'b0001) begin bad++; $display("FAIL reset_bnc got=%b exp=0001", d_bnc); end
        total++; if (d_div !== 4'b0001) begin bad++; $display("FAIL reset_div got=%b exp=0001", d_div); end
        total++; if (d_rr  !== 4'b1110) begin bad++; $display("FAIL reset_rr got=%b exp=1110", d_rr); end
        // The 20 ns edge occurs with reset held: nothing may move.
        @(posedge clock); #5;
        total++; if (d_def !== 4'b0001) begin bad++; $display("FAIL reset_edge_def got=%b exp=0001", d_def); end
        total++; if (d_rr  !== 4'b1110) begin bad++; $display("FAIL reset_edge_rr got=%b exp=1110", d_rr); end
        #5 reset_n = 1'b1;   // release at 30 ns
    endtask

    task automatic test_sequences(input string tag, input int n_edges);
        logic [3:0] e;
        for (int i = 0; i < n_edges; i++) begin
            q_def.push_back(exp_def[i]);
            q_bnc.push_back(exp_bnc[i]);
            q_div.push_back(exp_div[i]);
            q_rr.push_back(exp_rr[i]);
            @(posedge clock); #5;
            e = q_def.pop_front();
            total++; if (d_def !== e) begin bad++; $display("FAIL %s_def edge=%0d got=%b exp=%b", tag, i + 1, d_def, e); end
            total++; if ($countones(d_def) != 1) begin bad++; $display("FAIL %s_onehot edge=%0d got=%b exp=one bit", tag, i + 1, d_def); end
            e = q_bnc.pop_front();
            total++; if (d_bnc !== e) begin bad++; $display("FAIL %s_bnc edge=%0d got=%b exp=%b", tag, i + 1, d_bnc, e); end
            e = q_div.pop_front();
            total++; if (d_div !== e) begin bad++; $display("FAIL %s_div edge=%0d got=%b exp=%b", tag, i + 1, d_div, e); end
            e = q_rr.pop_front();
            total++; if (d_rr !== e) begin bad++; $display("FAIL %s_rr edge=%0d got=%b exp=%b", tag, i + 1, d_rr, e); end
        end
    endtask

    task automatic test_mid_reset();
        // Entered 5 ns after an edge with d_def at 0100 (edge 10).
        total++; if (d_def !== 4'b0100) begin bad++; $display("FAIL mid_pre got=%b exp=0100", d_def); end
        #5 reset_n = 1'b0;
        #1;
        total++; if (d_def !== 4'b0001) begin bad++; $display("FAIL mid_async_def got=%b exp=0001", d_def); end
        total++; if (d_bnc !== 4'b0001) begin bad++; $display("FAIL mid_async_bnc got=%b exp=0001", d_bnc); end
        total++; if (d_div !== 4'b0001) begin bad++; $display("FAIL mid_async_div got=%b exp=0001", d_div); end
        total++; if (d_rr  !== 4'b1110) begin bad++; $display("FAIL mid_async_rr got=%b exp=1110", d_rr); end
        // Hold reset across one edge, then release between edges.
        @(posedge clock); #5;
        total++; if (d_def !== 4'b0001) begin bad++; $display("FAIL mid_held_def got=%b exp=0001", d_def); end
        total++; if (d_div !== 4'b0001) begin bad++; $display("FAIL mid_held_div got=%b exp=0001", d_div); end
        #5 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        #10 reset_n = 1'b0;
        test_reset();
        test_sequences("run", 10);
        test_mid_reset();
        test_sequences("restart", 6);
        if (q_def.size() != 0 || q_bnc.size() != 0 || q_div.size() != 0 || q_rr.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q_def.size() + q_bnc.size() + q_div.size() + q_rr.size());
        end
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
